// File: rtl/global_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : global_buffer_pkg
//  Description : Shared types and constants for the global buffer endpoint:
//                instruction encoding, FSM state encoding, length width.
//  Revision    : 1.0 - initial release
// ============================================================================
package global_buffer_pkg;

    // Controller instruction encoding; unlisted codes behave as NOP.
    typedef enum logic [3:0] {
        GB_NOP             = 4'd0,
        GB_POINTER_RESET   = 4'd1,
        GB_LOAD_WEIGHT     = 4'd2,
        GB_LOAD_ACTIVATION = 4'd3,
        GB_LOAD_OUTPUT     = 4'd4,
        GB_READ_ACTIVATION = 4'd5
    } global_buffer_instruction_t;

    typedef enum logic [1:0] {
        GB_IDLE  = 2'd0,
        GB_LOAD  = 2'd1,
        GB_READ  = 2'd2,
        GB_DRAIN = 2'd3
    } gb_state_t;

    localparam int GB_LEN_W = 16;

endpackage : global_buffer_pkg
`default_nettype wire

// File: rtl/global_buffer_sram.sv
`default_nettype none
// ============================================================================
//  Module      : gb_sram
//  Description : Single-port storage array, synchronous write, registered
//                read with one cycle of latency. Read data holds between reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module gb_sram #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // One access per cycle: write when we_i, otherwise capture the read word.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule : gb_sram
`default_nettype wire

// File: rtl/global_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : global_buffer
//  Description : Buffer-side endpoint. Loads weight/activation words from the
//                write port, streams activations back on rd_data, executes
//                controller instructions. Holds FSM, pointers and counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module global_buffer
    import global_buffer_pkg::*;
#(
    parameter int dataSize       = 8,
    parameter int interfaceDepth = 16,
    parameter int addrWidth      = 32,
    parameter int bufDepth       = 256,
    parameter int lenWidth       = GB_LEN_W
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [3:0]                         instr_i,
    input  logic                               instr_valid_i,
    output logic                               instr_ready_o,
    input  logic [lenWidth-1:0]                len_i,
    input  logic [addrWidth-1:0]               weight_start_addr,
    input  logic [addrWidth-1:0]               activation_start_addr,
    input  logic [interfaceDepth*dataSize-1:0] wr_data,
    input  logic                               wr_en,
    output logic                               ready_o,
    output logic [interfaceDepth*dataSize-1:0] rd_data,
    output logic                               rd_data_valid,
    output logic                               done_o
);

    localparam int IW = interfaceDepth * dataSize;
    localparam int PW = $clog2(bufDepth);

    gb_state_t           state_q;
    logic [PW-1:0]       w_ptr_q, a_ptr_q, r_ptr_q;
    logic [lenWidth-1:0] cnt_q;
    logic                tgt_act_q;   // 1: activation region, 0: weight region
    logic                done_q;
    logic                rd_valid_q;
    logic [IW-1:0]       rd_hold_q;

    logic                accept_w, beat_w, is_xfer_w, last_w;
    logic [PW-1:0]       wr_addr_w, rd_addr_w, sram_addr_w;
    logic                sram_en_w;
    logic [IW-1:0]       sram_rdata_w;
    logic                w_unused_addr_bits;

    assign instr_ready_o = (state_q == GB_IDLE);
    assign ready_o       = (state_q == GB_LOAD);
    assign accept_w      = instr_valid_i && instr_ready_o;
    assign beat_w        = wr_en && ready_o;
    assign last_w        = (cnt_q == lenWidth'(1));

    // Only LOAD/READ instructions carry a length and report completion.
    assign is_xfer_w = (instr_i == GB_LOAD_WEIGHT)     || (instr_i == GB_LOAD_ACTIVATION) ||
                       (instr_i == GB_LOAD_OUTPUT)     || (instr_i == GB_READ_ACTIVATION);

    // Addresses wrap modulo bufDepth by PW-bit truncation.
    assign wr_addr_w   = tgt_act_q ? (activation_start_addr[PW-1:0] + a_ptr_q)
                                   : (weight_start_addr[PW-1:0] + w_ptr_q);
    assign rd_addr_w   = activation_start_addr[PW-1:0] + r_ptr_q;
    assign sram_en_w   = beat_w || (state_q == GB_READ);
    assign sram_addr_w = beat_w ? wr_addr_w : rd_addr_w;

    assign w_unused_addr_bits = ^{weight_start_addr[addrWidth-1:PW],
                                  activation_start_addr[addrWidth-1:PW]};

    gb_sram #(
        .WIDTH (IW),
        .DEPTH (bufDepth),
        .AW    (PW)
    ) u_sram (
        .clk     (clk),
        .en_i    (sram_en_w),
        .we_i    (beat_w),
        .addr_i  (sram_addr_w),
        .wdata_i (wr_data),
        .rdata_o (sram_rdata_w)
    );

    // Show the SRAM word while valid, otherwise the last delivered word.
    assign rd_data       = rd_valid_q ? sram_rdata_w : rd_hold_q;
    assign rd_data_valid = rd_valid_q;
    assign done_o        = done_q;

    // Control FSM with pointers, beat counter and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= GB_IDLE;
            w_ptr_q    <= '0;
            a_ptr_q    <= '0;
            r_ptr_q    <= '0;
            cnt_q      <= '0;
            tgt_act_q  <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_hold_q  <= '0;
        end else begin
            done_q     <= 1'b0;
            rd_valid_q <= (state_q == GB_READ);
            if (rd_valid_q) begin
                rd_hold_q <= sram_rdata_w;
            end
            case (state_q)
                GB_IDLE: begin
                    if (accept_w) begin
                        cnt_q <= len_i;
                        case (instr_i)
                            GB_POINTER_RESET: begin
                                w_ptr_q <= '0;
                                a_ptr_q <= '0;
                                r_ptr_q <= '0;
                            end
                            GB_LOAD_WEIGHT: begin
                                tgt_act_q <= 1'b0;
                                if (len_i != '0) state_q <= GB_LOAD;
                            end
                            // Output words land in the activation region for the next layer.
                            GB_LOAD_ACTIVATION, GB_LOAD_OUTPUT: begin
                                tgt_act_q <= 1'b1;
                                if (len_i != '0) state_q <= GB_LOAD;
                            end
                            GB_READ_ACTIVATION: begin
                                if (len_i != '0) state_q <= GB_READ;
                            end
                            default: ;
                        endcase
                        if (is_xfer_w && (len_i == '0)) begin
                            done_q <= 1'b1;
                        end
                    end
                end
                GB_LOAD: begin
                    if (beat_w) begin
                        if (tgt_act_q) a_ptr_q <= a_ptr_q + 1'b1;
                        else           w_ptr_q <= w_ptr_q + 1'b1;
                        cnt_q <= cnt_q - 1'b1;
                        if (last_w) begin
                            state_q <= GB_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                GB_READ: begin
                    r_ptr_q <= r_ptr_q + 1'b1;
                    cnt_q   <= cnt_q - 1'b1;
                    // done_o lines up with the last valid word shown in DRAIN.
                    if (last_w) begin
                        state_q <= GB_DRAIN;
                        done_q  <= 1'b1;
                    end
                end
                GB_DRAIN: begin
                    state_q <= GB_IDLE;
                end
                default: state_q <= GB_IDLE;
            endcase
        end
    end

endmodule : global_buffer
`default_nettype wire

// File: tb/tb_global_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_global_buffer
//  Description : Self-checking bench for global_buffer with a reference
//                memory/pointer model and a queue of expected read words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_global_buffer;
    import global_buffer_pkg::*;

    localparam int IW    = 128;
    localparam int DEPTH = 256;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      instr_i = 4'd0;
    logic            instr_valid_i = 1'b0;
    logic            instr_ready_o;
    logic [15:0]     len_i = 16'd0;
    logic [31:0]     weight_start_addr = 32'd0;
    logic [31:0]     activation_start_addr = 32'd0;
    logic [IW-1:0]   wr_data = '0;
    logic            wr_en = 1'b0;
    logic            ready_o;
    logic [IW-1:0]   rd_data;
    logic            rd_data_valid;
    logic            done_o;

    global_buffer #(
        .dataSize       (8),
        .interfaceDepth (16),
        .addrWidth      (32),
        .bufDepth       (DEPTH),
        .lenWidth       (16)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .instr_i               (instr_i),
        .instr_valid_i         (instr_valid_i),
        .instr_ready_o         (instr_ready_o),
        .len_i                 (len_i),
        .weight_start_addr     (weight_start_addr),
        .activation_start_addr (activation_start_addr),
        .wr_data               (wr_data),
        .wr_en                 (wr_en),
        .ready_o               (ready_o),
        .rd_data               (rd_data),
        .rd_data_valid         (rd_data_valid),
        .done_o                (done_o)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [IW-1:0] mdl [DEPTH];
    logic [7:0]    m_w = 8'd0, m_a = 8'd0, m_r = 8'd0;
    logic [IW-1:0] exp_q [$];

    task automatic check(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every valid read word must match the next queued word.
    always @(negedge clk) begin
        if (!rst && rd_data_valid) begin
            if (exp_q.size() == 0) check("rd_unexpected", IW'(rd_data_valid), IW'(0));
            else                   check("rd_data", rd_data, exp_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input int len);
        int t = 0;
        while (!instr_ready_o && t < 50) begin
            step();
            t++;
        end
        check("issue_ready", IW'(instr_ready_o), IW'(1));
        instr_i       = op;
        len_i         = 16'(len);
        instr_valid_i = 1'b1;
        step();
        instr_valid_i = 1'b0;
        if (op == GB_POINTER_RESET) begin
            m_w = 8'd0; m_a = 8'd0; m_r = 8'd0;
        end
    endtask

    task automatic beat(input logic [IW-1:0] d, input bit to_w);
        logic [7:0] ad;
        if (to_w) begin
            ad = weight_start_addr[7:0] + m_w;
            m_w++;
        end else begin
            ad = activation_start_addr[7:0] + m_a;
            m_a++;
        end
        mdl[ad] = d;
        wr_data = d;
        wr_en   = 1'b1;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic load(input logic [3:0] op, input int n, input logic [IW-1:0] d0, input int gap);
        issue(op, n);
        if (n == 0) begin
            check("done_len0", IW'(done_o), IW'(1));
            check("idle_len0", IW'(ready_o), IW'(0));
        end
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                check("ready_stall", IW'(ready_o), IW'(1));
                step();
            end
            beat(d0 + IW'(i), op == GB_LOAD_WEIGHT);
            check("load_done", IW'(done_o), IW'(i == n - 1));
        end
        check("load_idle", IW'(instr_ready_o), IW'(1));
        step();
        check("done_pulse_end", IW'(done_o), IW'(0));
    endtask

    task automatic rd(input int n, input bit hold_pr);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mdl[activation_start_addr[7:0] + m_r]);
            m_r++;
        end
        issue(GB_READ_ACTIVATION, n);
        if (hold_pr) begin
            instr_i       = GB_POINTER_RESET;
            instr_valid_i = 1'b1;
        end
        step();
        for (int i = 0; i < n; i++) begin
            check("rd_valid", IW'(rd_data_valid), IW'(1));
            check("rd_done", IW'(done_o), IW'(i == n - 1));
            if (hold_pr) check("instr_held", IW'(instr_ready_o), IW'(0));
            step();
        end
        check("rd_valid_end", IW'(rd_data_valid), IW'(0));
        if (hold_pr) begin
            check("instr_idle_ready", IW'(instr_ready_o), IW'(1));
            step();
            instr_valid_i = 1'b0;
            m_w = 8'd0; m_a = 8'd0; m_r = 8'd0;
        end
        check("rd_queue_empty", IW'(exp_q.size()), IW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [IW-1:0] held;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        // Reset state
        check("rst_instr_ready", IW'(instr_ready_o), IW'(1));
        check("rst_ready", IW'(ready_o), IW'(0));
        check("rst_rd_data", rd_data, IW'(0));
        check("rst_rd_valid", IW'(rd_data_valid), IW'(0));
        check("rst_done", IW'(done_o), IW'(0));

        // 1: reset mid-LOAD with three beats outstanding
        activation_start_addr = 32'd8;
        weight_start_addr     = 32'd100;
        issue(GB_LOAD_ACTIVATION, 5);
        beat(IW'('h11), 1'b0);
        beat(IW'('h12), 1'b0);
        check("midload_ready", IW'(ready_o), IW'(1));
        rst = 1'b1;
        #2;
        check("async_rst_ready", IW'(ready_o), IW'(0));
        step();
        rst = 1'b0;
        m_w = 8'd0; m_a = 8'd0; m_r = 8'd0;
        for (int i = 0; i < 3; i++) begin
            check("postrst_done", IW'(done_o), IW'(0));
            check("postrst_valid", IW'(rd_data_valid), IW'(0));
            check("postrst_idle", IW'(instr_ready_o), IW'(1));
            step();
        end
        issue(GB_POINTER_RESET, 0);
        rd(2, 1'b0);

        // 2: load four activations at base 8 and read them back
        issue(GB_POINTER_RESET, 0);
        load(GB_LOAD_ACTIVATION, 4, IW'('hA0), 0);
        rd(4, 1'b0);
        held = mdl[11];
        step();
        check("rd_hold", rd_data, held);

        // 3: weight load with stalls, checked through the activation read path
        load(GB_LOAD_WEIGHT, 2, IW'('h55), 3);
        activation_start_addr = 32'd100;
        issue(GB_POINTER_RESET, 0);
        rd(2, 1'b0);

        // 4: wrap around the top of the buffer
        activation_start_addr = 32'd254;
        issue(GB_POINTER_RESET, 0);
        load(GB_LOAD_ACTIVATION, 4, IW'('hC0), 0);
        rd(4, 1'b0);

        // 5: zero-length load, undefined opcode, wr_en while idle
        activation_start_addr = 32'd8;
        issue(GB_POINTER_RESET, 0);
        load(GB_LOAD_ACTIVATION, 0, IW'('hEE), 0);
        issue(4'hF, 3);
        check("undef_idle", IW'(instr_ready_o), IW'(1));
        check("undef_no_done", IW'(done_o), IW'(0));
        wr_data = IW'('hDEAD);
        wr_en   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check("idle_wr_ready", IW'(ready_o), IW'(0));
            step();
        end
        wr_en = 1'b0;
        rd(4, 1'b0);

        // 6: LOAD_OUTPUT appends after LOAD_ACTIVATION; instruction held during READ
        activation_start_addr = 32'd40;
        issue(GB_POINTER_RESET, 0);
        load(GB_LOAD_ACTIVATION, 2, IW'('h10), 0);
        load(GB_LOAD_OUTPUT, 2, IW'('h20), 0);
        issue(GB_POINTER_RESET, 0);
        rd(4, 1'b1);
        rd(1, 1'b0);

        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_global_buffer
`default_nettype wire
